// File: rtl/matrix_6up_12bpp_pkg.sv
// Shared constants and types for the 6-up 12bpp matrix driver write-side logic.
// Covers pixel geometry, fill extent, swap timeout default and FSM/arbiter encodings.
package matrix_6up_12bpp_pkg;

  localparam int ADDR_W           = 13;
  localparam int DATA_W           = 12;
  localparam int FILL_LAST        = 8191;
  // A 50 MHz frame is roughly 230k cycles, so this allows about two frames for adoption.
  localparam int SWAP_TIMEOUT_DEF = 524288;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } wr_state_e;

  typedef enum logic {
    RR_HOST = 1'b0,
    RR_FILL = 1'b1
  } rr_owner_e;

  // Full frame-buffer address: buffer bit on top of the pixel address.
  function automatic logic [ADDR_W:0] buf_addr(input logic buf_bit,
                                               input logic [ADDR_W-1:0] pix_addr);
    return {buf_bit, pix_addr};
  endfunction

endpackage

// File: rtl/matrix_6up_12bpp_rr_arb2.sv
// Two-way round-robin arbiter between the host stream and the fill engine.
// The owner flop only flips on contended cycles, so contention alternates strictly.
module matrix_6up_12bpp_rr_arb2
  import matrix_6up_12bpp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic host_valid,
  input  logic fill_active,
  input  logic blocked,
  output logic host_ready,
  output logic host_grant,
  output logic fill_grant
);

  rr_owner_e rr_q;
  rr_owner_e rr_d;
  logic      contend;

  always_comb begin
    rr_d       = rr_q;
    contend    = host_valid && fill_active && !blocked;
    host_ready = !blocked && (!fill_active || !host_valid || (rr_q == RR_HOST));
    host_grant = host_valid && host_ready;
    fill_grant = fill_active && !blocked && (!host_valid || (rr_q == RR_FILL));
    if (contend) begin
      rr_d = (rr_q == RR_HOST) ? RR_FILL : RR_HOST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= RR_HOST;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/matrix_6up_12bpp_wr_sched.sv
// Frame-buffer write-port scheduler: host/fill arbitration onto the back buffer and
// double-buffer swap sequencing against the driver's end-of-frame buffer adoption.
module matrix_6up_12bpp_wr_sched
  import matrix_6up_12bpp_pkg::*;
#(
  parameter int SWAP_TIMEOUT = SWAP_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  input  logic              swap_req,
  output logic              swap_busy,
  output logic              swap_done,
  output logic              swap_err,
  output logic              buffer_select,
  input  logic              buffer_current,
  output logic              wr,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int TMO_W = (SWAP_TIMEOUT > 2) ? $clog2(SWAP_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(SWAP_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] FILL_END = ADDR_W'(FILL_LAST);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              swap_pending_q, swap_pending_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              buffer_select_q, buffer_select_d;
  logic              swap_done_q, swap_done_d;
  logic              swap_err_q, swap_err_d;
  logic              wr_q, wr_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic arb_host_ready;
  logic host_grant;
  logic fill_grant;
  logic arb_blocked;

  // Reset also blocks the arbiter so host_ready reads low while rst_n is held.
  assign arb_blocked = !rst_n || (state_q == ST_SWAP_WAIT);

  matrix_6up_12bpp_rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_valid  (host_valid),
    .fill_active (state_q == ST_FILL),
    .blocked     (arb_blocked),
    .host_ready  (arb_host_ready),
    .host_grant  (host_grant),
    .fill_grant  (fill_grant)
  );

  always_comb begin
    state_d         = state_q;
    fill_addr_d     = fill_addr_q;
    fill_data_d     = fill_data_q;
    swap_pending_d  = swap_pending_q || swap_req;
    tmo_cnt_d       = tmo_cnt_q;
    buffer_select_d = buffer_select_q;
    swap_done_d     = 1'b0;
    swap_err_d      = 1'b0;
    wr_d            = host_grant || fill_grant;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;

    // Back-buffer bit is taken from the current select, so a grant on the swap edge
    // still lands in the buffer that was the back buffer when it was granted.
    if (host_grant) begin
      wr_addr_d = buf_addr(~buffer_select_q, host_addr);
      wr_data_d = host_data;
    end else if (fill_grant) begin
      wr_addr_d = buf_addr(~buffer_select_q, fill_addr_q);
      wr_data_d = fill_data_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          fill_data_d = fill_data;
          fill_addr_d = '0;
          state_d     = ST_FILL;
        end else if (swap_pending_q || swap_req) begin
          state_d         = ST_SWAP_WAIT;
          buffer_select_d = ~buffer_select_q;
          swap_pending_d  = 1'b0;
          tmo_cnt_d       = '0;
        end
      end
      ST_FILL: begin
        if (fill_grant) begin
          if (fill_addr_q == FILL_END) begin
            state_d = ST_IDLE;
          end else begin
            fill_addr_d = fill_addr_q + ADDR_W'(1);
          end
        end
      end
      ST_SWAP_WAIT: begin
        if (buffer_current == buffer_select_q) begin
          swap_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (tmo_cnt_q == TMO_MAX) begin
          swap_err_d      = 1'b1;
          buffer_select_d = buffer_current;
          state_d         = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      fill_addr_q     <= '0;
      fill_data_q     <= '0;
      swap_pending_q  <= 1'b0;
      tmo_cnt_q       <= '0;
      buffer_select_q <= 1'b0;
      swap_done_q     <= 1'b0;
      swap_err_q      <= 1'b0;
      wr_q            <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      fill_addr_q     <= fill_addr_d;
      fill_data_q     <= fill_data_d;
      swap_pending_q  <= swap_pending_d;
      tmo_cnt_q       <= tmo_cnt_d;
      buffer_select_q <= buffer_select_d;
      swap_done_q     <= swap_done_d;
      swap_err_q      <= swap_err_d;
      wr_q            <= wr_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
    end
  end

  assign host_ready    = arb_host_ready;
  assign fill_busy     = (state_q == ST_FILL);
  assign swap_busy     = swap_pending_q || (state_q == ST_SWAP_WAIT);
  assign swap_done     = swap_done_q;
  assign swap_err      = swap_err_q;
  assign buffer_select = buffer_select_q;
  assign wr            = wr_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_matrix_6up_12bpp_wr_sched.sv
// Bench for the write scheduler: random host traffic over fills and swaps, compared
// against a cycle-level reference of grants, fill sequence and swap outcomes.
module tb_matrix_6up_12bpp_wr_sched;
  import matrix_6up_12bpp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, host_valid, fill_start, swap_req, buffer_current;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data, fill_data;

  logic              host_ready, fill_busy, swap_busy, swap_done, swap_err, buffer_select, wr;
  logic [ADDR_W:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              t_host_ready, t_fill_busy, t_swap_busy, t_swap_done, t_swap_err;
  logic              t_buffer_select, t_wr;
  logic [ADDR_W:0]   t_wr_addr;
  logic [DATA_W-1:0] t_wr_data;

  int vecs = 0;
  int errs = 0;

  matrix_6up_12bpp_wr_sched dut (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data), .fill_start(fill_start),
    .fill_data(fill_data), .fill_busy(fill_busy), .swap_req(swap_req),
    .swap_busy(swap_busy), .swap_done(swap_done), .swap_err(swap_err),
    .buffer_select(buffer_select), .buffer_current(buffer_current),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Short-timeout instance used for the swap abort scenario.
  matrix_6up_12bpp_wr_sched #(.SWAP_TIMEOUT(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(t_host_ready),
    .host_addr(host_addr), .host_data(host_data), .fill_start(fill_start),
    .fill_data(fill_data), .fill_busy(t_fill_busy), .swap_req(swap_req),
    .swap_busy(t_swap_busy), .swap_done(t_swap_done), .swap_err(t_swap_err),
    .buffer_select(t_buffer_select), .buffer_current(buffer_current),
    .wr(t_wr), .wr_addr(t_wr_addr), .wr_data(t_wr_data)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; host_valid = 1'b0; fill_start = 1'b0; swap_req = 1'b0;
    buffer_current = 1'b0; host_addr = '0; host_data = '0; fill_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    rst_n = 1'b0; host_valid = 1'b1; fill_start = 1'b1; swap_req = 1'b1;
    host_addr = ADDR_W'($urandom); host_data = DATA_W'($urandom); buffer_current = 1'b0;
    repeat (3) tick();
    #1;
    flags = {wr, fill_busy, swap_busy, swap_done, swap_err, buffer_select, host_ready};
    vecs++; if (flags !== 7'b0) begin errs++; $display("FAIL reset_flags: got %b want 0000000", flags); end
    vecs++; if (wr_addr !== '0) begin errs++; $display("FAIL reset_addr: got %h want 0", wr_addr); end
    vecs++; if (wr_data !== '0) begin errs++; $display("FAIL reset_data: got %h want 0", wr_data); end
    host_valid = 1'b0; fill_start = 1'b0; swap_req = 1'b0; rst_n = 1'b1;
    tick();
    vecs++; if (wr !== 1'b0) begin errs++; $display("FAIL post_reset_wr: got %b want 0", wr); end
    host_valid = 1'b1; host_addr = 13'h0123; host_data = 12'hABC;
    #1;
    vecs++; if (host_ready !== 1'b1) begin errs++; $display("FAIL first_ready: got %b want 1", host_ready); end
    tick();
    host_valid = 1'b0;
    vecs++;
    if (wr !== 1'b1 || wr_addr !== 14'h2123 || wr_data !== 12'hABC) begin
      errs++; $display("FAIL first_write: got wr=%b %h/%h want 1 2123/abc", wr, wr_addr, wr_data);
    end
    $display("host wr addr=%h data=%h", wr_addr, wr_data);
    tick();
    vecs++; if (wr !== 1'b0) begin errs++; $display("FAIL idle_wr: got %b want 0", wr); end
  endtask

  task automatic test_fill_idle();
    int busy_cycles = 0;
    logic [ADDR_W:0] exp_a;
    do_reset();
    fill_data = 12'hF00; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 8192; k++) begin
      if (fill_busy) busy_cycles++;
      tick();
      exp_a = {1'b1, ADDR_W'(k)};
      vecs++;
      if (wr !== 1'b1 || wr_addr !== exp_a || wr_data !== 12'hF00) begin
        errs++; $display("FAIL fill_word: got wr=%b %h/%h want 1 %h/f00", wr, wr_addr, wr_data, exp_a);
      end
    end
    vecs++; if (fill_busy !== 1'b0) begin errs++; $display("FAIL fill_end_busy: got %b want 0", fill_busy); end
    vecs++; if (busy_cycles != 8192) begin errs++; $display("FAIL fill_busy_len: got %0d want 8192", busy_cycles); end
    tick();
    vecs++; if (wr !== 1'b0) begin errs++; $display("FAIL fill_after_wr: got %b want 0", wr); end
    $display("fill idle: %0d busy cycles, colour f00", busy_cycles);
  endtask

  task automatic test_contention();
    logic [DATA_W-1:0] fc;
    logic [ADDR_W-1:0] sa;
    logic [DATA_W-1:0] sd;
    logic exp_h;
    int fidx = 0;
    int cyc = 0;
    do_reset();
    fc = DATA_W'($urandom); fill_data = fc; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    host_addr = ADDR_W'($urandom); host_data = DATA_W'($urandom);
    while (fidx < 8192 && cyc < 20000) begin
      host_valid = 1'b1;
      #1;
      exp_h = (cyc % 2 == 0);
      vecs++; if (host_ready !== exp_h) begin errs++; $display("FAIL alt_ready: got %b want %b", host_ready, exp_h); end
      sa = host_addr; sd = host_data;
      tick();
      cyc++;
      vecs++;
      if (exp_h) begin
        if (wr !== 1'b1 || wr_addr !== {1'b1, sa} || wr_data !== sd) begin
          errs++; $display("FAIL alt_host: got wr=%b %h/%h want 1 %h/%h", wr, wr_addr, wr_data, {1'b1, sa}, sd);
        end
        host_addr = ADDR_W'($urandom); host_data = DATA_W'($urandom);
      end else begin
        if (wr !== 1'b1 || wr_addr !== {1'b1, ADDR_W'(fidx)} || wr_data !== fc) begin
          errs++; $display("FAIL alt_fill: got wr=%b %h/%h want 1 %h/%h", wr, wr_addr, wr_data, {1'b1, ADDR_W'(fidx)}, fc);
        end
        fidx++;
      end
    end
    host_valid = 1'b0;
    vecs++; if (fill_busy !== 1'b0) begin errs++; $display("FAIL alt_done: got %b want 0 after %0d cycles", fill_busy, cyc); end
    $display("contention fill: %0d cycles, %0d fill words", cyc, fidx);
  endtask

  task automatic test_random_mix();
    logic [DATA_W-1:0] fc;
    logic [ADDR_W-1:0] sa;
    logic [DATA_W-1:0] sd;
    logic acc;
    logic refused_prev = 1'b0;
    int exp_fill = 0;
    int tail = 0;
    int cyc = 0;
    do_reset();
    fc = DATA_W'($urandom); fill_data = fc; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    while (tail < 20 && cyc < 40000) begin
      host_valid = ($urandom_range(0, 2) != 0);
      host_addr = ADDR_W'($urandom); host_data = DATA_W'($urandom);
      #1;
      vecs++;
      if (fill_busy !== (exp_fill < 8192)) begin
        errs++; $display("FAIL mix_busy: got %b want %b", fill_busy, exp_fill < 8192);
      end
      if (host_valid) begin
        // Fill over: host always ready. Fill active: never refused twice in a row.
        vecs++;
        if ((exp_fill >= 8192 || refused_prev) && host_ready !== 1'b1) begin
          errs++; $display("FAIL mix_fair: got ready=%b want 1 (fill words %0d)", host_ready, exp_fill);
        end
        refused_prev = !host_ready;
      end
      acc = host_valid && host_ready;
      sa = host_addr; sd = host_data;
      tick();
      cyc++;
      vecs++;
      if (acc) begin
        if (wr !== 1'b1 || wr_addr !== {1'b1, sa} || wr_data !== sd) begin
          errs++; $display("FAIL mix_host: got wr=%b %h/%h want 1 %h/%h", wr, wr_addr, wr_data, {1'b1, sa}, sd);
        end
      end else if (exp_fill < 8192) begin
        if (wr !== 1'b1 || wr_addr !== {1'b1, ADDR_W'(exp_fill)} || wr_data !== fc) begin
          errs++; $display("FAIL mix_fill: got wr=%b %h/%h want 1 %h/%h", wr, wr_addr, wr_data, {1'b1, ADDR_W'(exp_fill)}, fc);
        end
        exp_fill++;
      end else begin
        if (wr !== 1'b0) begin errs++; $display("FAIL mix_idle: got wr=%b want 0", wr); end
      end
      if (exp_fill >= 8192) tail++;
    end
    host_valid = 1'b0;
    $display("random mix: %0d cycles, %0d fill words", cyc, exp_fill);
  endtask

  task automatic test_swap();
    logic [DATA_W-1:0] hd;
    do_reset();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    vecs++; if (buffer_select !== 1'b1 || swap_busy !== 1'b1) begin
      errs++; $display("FAIL swap_enter: got sel=%b busy=%b want 1 1", buffer_select, swap_busy);
    end
    for (int k = 0; k < 1000; k++) begin
      host_valid = 1'b1; host_addr = ADDR_W'($urandom);
      #1;
      vecs++; if (host_ready !== 1'b0) begin errs++; $display("FAIL swap_hold_ready: got %b want 0", host_ready); end
      tick();
      vecs++; if (wr !== 1'b0 || swap_done !== 1'b0 || buffer_select !== 1'b1) begin
        errs++; $display("FAIL swap_wait: got wr=%b done=%b sel=%b want 0 0 1", wr, swap_done, buffer_select);
      end
    end
    host_valid = 1'b0;
    buffer_current = buffer_select;
    tick();
    vecs++; if (swap_done !== 1'b1 || swap_busy !== 1'b0) begin
      errs++; $display("FAIL swap_done: got done=%b busy=%b want 1 0", swap_done, swap_busy);
    end
    hd = DATA_W'($urandom);
    host_valid = 1'b1; host_addr = 13'h0123; host_data = hd;
    #1;
    vecs++; if (host_ready !== 1'b1) begin errs++; $display("FAIL swap_ready_back: got %b want 1", host_ready); end
    tick();
    host_valid = 1'b0;
    vecs++; if (swap_done !== 1'b0) begin errs++; $display("FAIL swap_done_pulse: got %b want 0", swap_done); end
    vecs++; if (wr !== 1'b1 || wr_addr !== 14'h0123 || wr_data !== hd) begin
      errs++; $display("FAIL swap_host_wr: got wr=%b %h/%h want 1 0123/%h", wr, wr_addr, wr_data, hd);
    end
    $display("host wr addr=%h data=%h after swap", wr_addr, wr_data);
  endtask

  task automatic test_swap_fill();
    logic [DATA_W-1:0] fc;
    do_reset();
    fc = DATA_W'($urandom); fill_data = fc; fill_start = 1'b1; swap_req = 1'b1;
    tick();
    fill_start = 1'b0; swap_req = 1'b0;
    vecs++; if (fill_busy !== 1'b1 || swap_busy !== 1'b1 || buffer_select !== 1'b0) begin
      errs++; $display("FAIL sf_start: got fill=%b swap=%b sel=%b want 1 1 0", fill_busy, swap_busy, buffer_select);
    end
    for (int k = 0; k < 8192; k++) begin
      swap_req = (k == 4000);
      tick();
      vecs++;
      if (wr !== 1'b1 || wr_addr !== {1'b1, ADDR_W'(k)} || wr_data !== fc || buffer_select !== 1'b0) begin
        errs++; $display("FAIL sf_fill: got wr=%b %h/%h sel=%b want 1 %h/%h 0", wr, wr_addr, wr_data, buffer_select, {1'b1, ADDR_W'(k)}, fc);
      end
    end
    swap_req = 1'b0;
    vecs++; if (fill_busy !== 1'b0 || swap_busy !== 1'b1 || buffer_select !== 1'b0) begin
      errs++; $display("FAIL sf_fill_end: got fill=%b swap=%b sel=%b want 0 1 0", fill_busy, swap_busy, buffer_select);
    end
    tick();
    vecs++; if (buffer_select !== 1'b1 || swap_busy !== 1'b1) begin
      errs++; $display("FAIL sf_swap_enter: got sel=%b busy=%b want 1 1", buffer_select, swap_busy);
    end
    buffer_current = buffer_select;
    tick();
    vecs++; if (swap_done !== 1'b1 || swap_busy !== 1'b0) begin
      errs++; $display("FAIL sf_swap_done: got done=%b busy=%b want 1 0", swap_done, swap_busy);
    end
    tick();
    vecs++; if (swap_done !== 1'b0 || swap_busy !== 1'b0 || buffer_select !== 1'b1) begin
      errs++; $display("FAIL sf_merged: got done=%b busy=%b sel=%b want 0 0 1", swap_done, swap_busy, buffer_select);
    end
    $display("fill then swap: fill colour %h, now displaying buffer %0d", fc, buffer_select);
  endtask

  task automatic test_timeout();
    int n = 0;
    logic got = 1'b0;
    do_reset();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    vecs++; if (t_buffer_select !== 1'b1) begin errs++; $display("FAIL to_enter: got %b want 1", t_buffer_select); end
    while (n < 200 && !got) begin
      tick();
      n++;
      if (t_swap_err) got = 1'b1;
    end
    vecs++; if (!got || n != 64) begin errs++; $display("FAIL to_cycle: got err=%b at %0d want 1 at 64", got, n); end
    vecs++; if (t_buffer_select !== 1'b0) begin errs++; $display("FAIL to_revert: got %b want 0", t_buffer_select); end
    tick();
    vecs++; if (t_swap_err !== 1'b0 || t_swap_busy !== 1'b0) begin
      errs++; $display("FAIL to_after: got err=%b busy=%b want 0 0", t_swap_err, t_swap_busy);
    end
    $display("swap timeout: swap_err after %0d cycles", n);
  endtask

  task automatic test_reset_midfill();
    do_reset();
    fill_data = DATA_W'($urandom); fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (100) tick();
    vecs++; if (wr !== 1'b1 || fill_busy !== 1'b1) begin
      errs++; $display("FAIL mid_running: got wr=%b busy=%b want 1 1", wr, fill_busy);
    end
    rst_n = 1'b0;
    tick();
    vecs++; if (wr !== 1'b0 || fill_busy !== 1'b0) begin
      errs++; $display("FAIL mid_reset: got wr=%b busy=%b want 0 0", wr, fill_busy);
    end
    rst_n = 1'b1;
    tick();
    vecs++; if (wr !== 1'b0 || fill_busy !== 1'b0) begin
      errs++; $display("FAIL mid_release: got wr=%b busy=%b want 0 0", wr, fill_busy);
    end
    $display("reset mid-fill: fill aborted");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_idle();
    test_contention();
    test_random_mix();
    test_swap();
    test_swap_fill();
    test_timeout();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
